// File: rtl/memory_responder.sv
// Word-addressed memory answering MAR/MDR requests after WAIT_CYCLES edges.
// Optional feature macro MEM_ERR_EN adds mem_err for illegal strobes and out-of-range addresses.
module memory_responder #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       mar_in,
    input  logic [DATA_W-1:0] mdr_out,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_busy,
    output logic              mem_done
`ifdef MEM_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam int unsigned Depth    = 1 << ADDR_W;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
`ifdef MEM_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic              oob_q;
    logic [DATA_W-1:0] mdata_q;
    logic              busy_q;
    logic              done_q;
`ifdef MEM_ERR_EN
    logic              err_q;
    logic              req_both;
`endif

    logic [DATA_W-1:0] mem [Depth];

    logic req_one;
    logic oob_in;
    logic commit;
    logic mem_we;

    assign req_one = Read ^ Write;
`ifdef MEM_ERR_EN
    assign req_both = Read & Write;
`endif
    // Upper address bits only matter when they can be reported; otherwise the address wraps.
    assign oob_in  = ErrEn && (mar_in[31:ADDR_W] != '0);
    assign commit  = (state_q == StBusy) && (cnt_q == 4'd1);
    assign mem_we  = !clr && commit && wr_q && !oob_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            mdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MEM_ERR_EN
            err_q  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (req_one) begin
                        state_q <= StBusy;
                        cnt_q   <= WaitInit;
                        addr_q  <= mar_in[ADDR_W-1:0];
                        data_q  <= mdr_out;
                        wr_q    <= Write;
                        oob_q   <= oob_in;
                        busy_q  <= 1'b1;
                    end
`ifdef MEM_ERR_EN
                    else if (req_both) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
`ifdef MEM_ERR_EN
                        err_q   <= oob_q;
`endif
                        if (!wr_q && !oob_q) begin
                            mdata_q <= mem[addr_q];
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Mdatain  = mdata_q;
    assign mem_busy = busy_q;
    assign mem_done = done_q;
`ifdef MEM_ERR_EN
    assign mem_err  = err_q;
`endif

endmodule
